mem_arbiter: RTL and testbench

- Two-requester arbiter/sequencer in front of the single-port 16-bit, 15-bit-address main memory.
- Port A is CPU data, port B is the DMA/screen-refresh agent.
- Serialises accesses, drives the memory's address/in/load, and captures its 1-cycle registered read data.
- Returns data to the winner with a one-cycle ack; out-of-range addresses are flagged.

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter/sequencer in front of a single-port registered-read memory
//
// Purpose: serialises port A (CPU data) and port B (DMA/refresh) accesses onto
// one memory. It drives mem_address/mem_in/mem_load, captures the memory's
// 1-cycle registered read data and returns it to the winning port with a
// one-cycle ack. Addresses above ADDR_LIMIT are not written, read back as 0
// and are flagged with err.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   - round-robin arbitration; a pointer names the port that wins a tie
//   undefined - fixed priority, port A always beats port B
//
// Ports:
//   clk, rst_n                  clock (posedge) and synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request, held stable until a_ack
//   a_ack/a_rdata/a_err         port A completion pulse, read data, range error
//   b_*                         same set for port B
//   mem_address/mem_in/mem_load memory address, write data, write strobe
//   mem_out                     memory read data (registered, 1-cycle latency)
//   busy                        high whenever the sequencer is not idle

module mem_arbiter #(
    parameter int                ADDR_W     = 15,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] ADDR_LIMIT = 15'h6000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t state_q;
    logic   win_b_q;   // 1 = port B owns the transaction in flight
    logic   we_q;
    logic   err_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic   rr_b_q;    // 1 = pointer names port B
`endif

    logic              grant_b;
    logic              sel_we;
    logic              sel_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        grant_b = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        grant_b = b_req & (~a_req | rr_b_q);
`else
        grant_b = b_req & ~a_req;
`endif
        sel_we    = grant_b ? b_we    : a_we;
        sel_addr  = grant_b ? b_addr  : a_addr;
        sel_wdata = grant_b ? b_wdata : a_wdata;
        sel_err   = sel_addr > ADDR_LIMIT;
        // Writes and out-of-range accesses return zero rather than whatever the memory drives.
        resp_data = (we_q | err_q) ? '0 : mem_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            win_b_q     <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            a_ack       <= 1'b0;
            a_err       <= 1'b0;
            a_rdata     <= '0;
            b_ack       <= 1'b0;
            b_err       <= 1'b0;
            b_rdata     <= '0;
            mem_address <= '0;
            mem_in      <= '0;
            mem_load    <= 1'b0;
            busy        <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_b_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (a_req | b_req) begin
                        mem_address <= sel_addr;
                        mem_in      <= sel_wdata;
                        mem_load    <= sel_we & ~sel_err;
                        win_b_q     <= grant_b;
                        we_q        <= sel_we;
                        err_q       <= sel_err;
                        busy        <= 1'b1;
                        state_q     <= S_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        // Pointer moves to the port that did not just win.
                        rr_b_q      <= ~grant_b;
`endif
                    end else begin
                        mem_load <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    mem_load <= 1'b0;
                    state_q  <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (win_b_q) begin
                        b_ack   <= 1'b1;
                        b_err   <= err_q;
                        b_rdata <= resp_data;
                    end else begin
                        a_ack   <= 1'b1;
                        a_err   <= err_q;
                        a_rdata <= resp_data;
                    end
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    // rdata is left holding the last response.
                    a_ack   <= 1'b0;
                    a_err   <= 1'b0;
                    b_ack   <= 1'b0;
                    b_err   <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural reference model

module tb_mem_arbiter;

    localparam logic [14:0] LIMIT = 15'h6000;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit USE_RR = 1'b1;
`else
    localparam bit USE_RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [14:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [15:0] a_rdata, b_rdata;
    logic [14:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] env_mem [0:32767];
    logic [15:0] ref_mem [0:32767];
    bit          ptr_b;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_address(mem_address), .mem_in(mem_in), .mem_load(mem_load),
        .mem_out(mem_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: registered read, ignores writes and returns 0 above LIMIT.
    always @(posedge clk) begin
        if (mem_load && mem_address <= LIMIT) env_mem[mem_address] <= mem_in;
        mem_out <= (mem_address <= LIMIT) ? env_mem[mem_address] : 16'h0;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_access(input bit we, input logic [14:0] addr, input logic [15:0] wd,
                                output logic [15:0] rd, output bit err, inout int loads);
        err = addr > LIMIT;
        rd  = (we || err) ? 16'h0 : ref_mem[addr];
        if (we && !err) begin
            ref_mem[addr] = wd;
            loads++;
        end
    endtask

    // Presents requests at the current time (just after a negedge) and checks
    // the completion order, latency, data, error flag and write-strobe count.
    task automatic run_round(input bit a_on, input bit aw, input logic [14:0] aa, input logic [15:0] ad,
                             input bit b_on, input bit bw, input logic [14:0] ba, input logic [15:0] bd);
        int          a_cyc, b_cyc, loads_exp, loads;
        logic [15:0] a_exp, b_exp;
        bit          a_eerr, b_eerr, a_seen, b_seen, first_b;
        a_cyc = 0; b_cyc = 0; loads_exp = 0; loads = 0;
        a_exp = '0; b_exp = '0; a_eerr = 0; b_eerr = 0; a_seen = 0; b_seen = 0;
        first_b = b_on && (!a_on || (USE_RR && ptr_b));
        if (first_b) begin
            model_access(bw, ba, bd, b_exp, b_eerr, loads_exp); b_cyc = 3; ptr_b = 1'b0;
            if (a_on) begin
                model_access(aw, aa, ad, a_exp, a_eerr, loads_exp); a_cyc = 7; ptr_b = 1'b1;
            end
        end else begin
            model_access(aw, aa, ad, a_exp, a_eerr, loads_exp); a_cyc = 3; ptr_b = 1'b1;
            if (b_on) begin
                model_access(bw, ba, bd, b_exp, b_eerr, loads_exp); b_cyc = 7; ptr_b = 1'b0;
            end
        end
        a_req = a_on; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = b_on; b_we = bw; b_addr = ba; b_wdata = bd;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_load) loads++;
            if (c == 1) chk_eq("busy_on", 32'(busy), 32'd1);
            if (a_ack) begin
                if (!a_on || a_seen) chk_eq("a_extra_ack", 32'd1, 32'd0);
                else begin
                    chk_eq("a_latency", 32'(c), 32'(a_cyc));
                    chk_eq("a_rdata", 32'(a_rdata), 32'(a_exp));
                    chk_eq("a_err", 32'(a_err), 32'(a_eerr));
                end
                a_seen = 1; a_req = 1'b0;
            end
            if (b_ack) begin
                if (!b_on || b_seen) chk_eq("b_extra_ack", 32'd1, 32'd0);
                else begin
                    chk_eq("b_latency", 32'(c), 32'(b_cyc));
                    chk_eq("b_rdata", 32'(b_rdata), 32'(b_exp));
                    chk_eq("b_err", 32'(b_err), 32'(b_eerr));
                end
                b_seen = 1; b_req = 1'b0;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        if (a_on) chk_eq("a_ack_seen", 32'(a_seen), 32'd1);
        if (b_on) chk_eq("b_ack_seen", 32'(b_seen), 32'd1);
        chk_eq("load_cycles", 32'(loads), 32'(loads_exp));
        chk_eq("busy_off", 32'(busy), 32'd0);
    endtask

    function automatic logic [14:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return 15'($urandom_range(0, 7));
            1:       return LIMIT + 15'($urandom_range(0, 2));
            default: return 15'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        for (int i = 0; i < 32768; i++) begin
            env_mem[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        ptr_b = 1'b0;
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0005; a_wdata = 16'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 15'h0; b_wdata = 16'h0;

        // Reset held with a request pending: nothing happens.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk_eq("rst_a_ack", 32'(a_ack), 32'd0);
            chk_eq("rst_mem_load", 32'(mem_load), 32'd0);
            chk_eq("rst_busy", 32'(busy), 32'd0);
            chk_eq("rst_mem_address", 32'(mem_address), 32'd0);
            chk_eq("rst_a_rdata", 32'(a_rdata), 32'd0);
        end
        rst_n = 1'b1;
        run_round(1, 0, 15'h0005, 16'h0, 0, 0, 15'h0, 16'h0);

        // A write then read back; out-of-range B write/read; boundary address.
        run_round(1, 1, 15'h0010, 16'h1234, 0, 0, 15'h0, 16'h0);
        run_round(1, 0, 15'h0010, 16'h0, 0, 0, 15'h0, 16'h0);
        run_round(0, 0, 15'h0, 16'h0, 1, 1, 15'h6001, 16'hBEEF);
        run_round(0, 0, 15'h0, 16'h0, 1, 0, 15'h6001, 16'h0);
        run_round(0, 0, 15'h0, 16'h0, 1, 1, 15'h6000, 16'h5A5A);
        run_round(0, 0, 15'h0, 16'h0, 1, 0, 15'h6000, 16'h0);

        // Simultaneous read rounds.
        run_round(1, 1, 15'h0001, 16'h1111, 1, 1, 15'h0002, 16'h2222);
        for (int r = 0; r < 3; r++) run_round(1, 0, 15'h0001, 16'h0, 1, 0, 15'h0002, 16'h0);

        // Reset during CAPTURE aborts; identical request then completes.
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_eq("abort_a_ack", 32'(a_ack), 32'd0);
        chk_eq("abort_busy", 32'(busy), 32'd0);
        chk_eq("abort_mem_load", 32'(mem_load), 32'd0);
        rst_n = 1'b1; a_req = 1'b0; ptr_b = 1'b0;
        @(negedge clk);
        chk_eq("abort_no_late_ack", 32'(a_ack), 32'd0);
        run_round(1, 0, 15'h0010, 16'h0, 0, 0, 15'h0, 16'h0);

        // A holds its request across the ack: two reads in 8 cycles.
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010; acks = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_ack) begin
                acks++;
                chk_eq("held_latency", 32'(c), 32'(acks * 4 - 1));
                chk_eq("held_rdata", 32'(a_rdata), 32'(ref_mem[15'h0010]));
                if (acks == 2) a_req = 1'b0;
            end
        end
        a_req = 1'b0;
        chk_eq("held_ack_count", 32'(acks), 32'd2);
        ptr_b = 1'b1;

        // Randomised rounds against the reference model.
        for (int r = 0; r < 40; r++) begin
            bit ao, bo;
            ao = 1'($urandom);
            bo = 1'($urandom);
            if (!ao && !bo) ao = 1'b1;
            run_round(ao, 1'($urandom), rand_addr(), 16'($urandom),
                      bo, 1'($urandom), rand_addr(), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
